unified_store_logic: RTL
========================

UNIFIED_STORE_LOGIC -- requirements
Module: unified_store_logic

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, is the word address width of each BRAM bank.
REQ-002 Parameter DATA_W, default 2*`OVERALL_BITS, is the result word width (real||imag, or packed NTT lanes).
REQ-003 Parameter FIFO_DEPTH, default 4, sets the per-bank conflict FIFO depth in entries.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 in_a_valid  in  1  result A present this cycle.
REQ-007 in_a_bank  in  1  destination bank of A.
REQ-008 in_a_addr  in  ADDR_WIDTH  destination word address of A.
REQ-009 in_a_data  in  DATA_W  result A.
REQ-010 in_b_valid, in_b_bank, in_b_addr, in_b_data  in  1/1/ADDR_WIDTH/DATA_W  same meaning for result B.
REQ-011 ctrl_done  in  1  pulse: upstream issued its last result.
REQ-012 wr_en_0, wr_addr_0, wr_data_0  out  1/ADDR_WIDTH/DATA_W  bank-0 write port.
REQ-013 wr_en_1, wr_addr_1, wr_data_1  out  1/ADDR_WIDTH/DATA_W  bank-1 write port.
REQ-014 pending_cnt_0, pending_cnt_1  out  $clog2(FIFO_DEPTH+1) each  FIFO occupancy per bank.
REQ-015 overflow  out  1  sticky; a result was dropped.
REQ-016 store_done  out  1  one-cycle pulse: all results written.

Function
REQ-017 Each bank SHALL perform at most one write per cycle; A and B with different banks SHALL write in parallel with no queuing.
REQ-018 Per bank k per cycle t, selection priority SHALL be FIFO_k head, then incoming A (bank k), then incoming B (bank k).
REQ-019 All valid incoming results for bank k that are not selected SHALL be pushed to FIFO_k, A before B.
REQ-020 Write outputs SHALL be registered: a selection at cycle t drives wr_en_k=1 with its addr/data at cycle t+1; no selection drives wr_en_k=0.
REQ-021 Per-bank write order SHALL equal arrival order, with A before B within a cycle.
REQ-022 Same bank and same address from A and B in one cycle SHALL NOT be merged: A is written first, B one or more cycles later.
REQ-023 A push and a pop in the same cycle SHALL be allowed: count_next = count + pushes - pop.
REQ-024 pending_cnt_k SHALL be the registered FIFO_k count.
REQ-025 If count + pushes - pop > FIFO_DEPTH, excess results (B first) SHALL be dropped, the count SHALL saturate at FIFO_DEPTH, and overflow SHALL be set from the next cycle until rst.
REQ-026 bank/addr/data SHALL be ignored when the matching valid is 0.
REQ-027 ctrl_done SHALL set a done latch.
REQ-028 store_done SHALL be 1 at t+1 when, at cycle t, (latch or ctrl_done)=1, pending_cnt_0=pending_cnt_1=0, and in_a_valid=in_b_valid=0; the latch SHALL clear at that point.
REQ-029 store_done SHALL be a single-cycle pulse and SHALL NOT coincide with any wr_en.

Reset
REQ-030 On rst=1 at a clock edge, wr_en_*, wr_addr_*, wr_data_*, pending_cnt_*, overflow, store_done and the done latch SHALL be 0 from the next cycle, and FIFO contents SHALL be discarded.
REQ-031 Inputs presented during rst SHALL be ignored; no write SHALL issue from pre-reset data.

Verification
REQ-032 A: bank0/addr5/0xAA and B: bank1/addr5/0xBB at t -> at t+1 wr_en_0=1 addr5 data 0xAA and wr_en_1=1 addr5 data 0xBB; pending_cnt both 0.
REQ-033 A: bank0/addr3 and B: bank0/addr7 at t -> write addr3 at t+1 and addr7 at t+2; pending_cnt_0=1 at t+1, 0 at t+2.
REQ-034 FIFO_DEPTH=4, both A and B to bank0 for 5 consecutive cycles -> pending_cnt_0 = 1,2,3,4,4; overflow=1 after the 5th cycle; the 5th cycle's B is never written; the other 9 writes occur in order.
REQ-035 Pending_cnt_0=2, ctrl_done pulse, no further inputs -> two bank-0 writes, then store_done=1 for exactly one cycle on the cycle following the last wr_en_0.
REQ-036 Pending_cnt_0=3, rst pulsed for one cycle -> next cycle all outputs 0, no queued write ever appears.
REQ-037 FIFO_0 holds addr1 and a new A: bank0/addr2 arrives -> addr1 is written before addr2.

Source files
------------

// File: rtl/unified_store_logic.sv
`default_nettype none
`ifndef OVERALL_BITS
`define OVERALL_BITS 16
`endif
// ============================================================================
// Module      : unified_store_logic
// Description : Routes two result streams into two single-write-port BRAM
//               banks, queueing bank conflicts in per-bank FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
module unified_store_logic #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_W     = 2*`OVERALL_BITS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_a_valid,
    input  logic                             in_a_bank,
    input  logic [ADDR_WIDTH-1:0]            in_a_addr,
    input  logic [DATA_W-1:0]                in_a_data,
    input  logic                             in_b_valid,
    input  logic                             in_b_bank,
    input  logic [ADDR_WIDTH-1:0]            in_b_addr,
    input  logic [DATA_W-1:0]                in_b_data,
    input  logic                             ctrl_done,
    output logic                             wr_en_0,
    output logic [ADDR_WIDTH-1:0]            wr_addr_0,
    output logic [DATA_W-1:0]                wr_data_0,
    output logic                             wr_en_1,
    output logic [ADDR_WIDTH-1:0]            wr_addr_1,
    output logic [DATA_W-1:0]                wr_data_1,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  pending_cnt_0,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  pending_cnt_1,
    output logic                             overflow,
    output logic                             store_done
);

    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [1:0]            w_wr_en;
    logic [1:0]            w_drop;
    logic [ADDR_WIDTH-1:0] w_wr_addr [2];
    logic [DATA_W-1:0]     w_wr_data [2];
    logic [CW-1:0]         w_count   [2];

    logic r_overflow;
    logic r_done_latch;
    logic r_store_done;
    logic w_fire;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_bank
        logic                  w_a_hit, w_b_hit, w_pop, w_sel;
        logic                  w_p0_v, w_p1_v, w_p0_ok, w_p1_ok;
        logic [ADDR_WIDTH-1:0] w_sel_addr, w_p0_addr;
        logic [DATA_W-1:0]     w_sel_data, w_p0_data;
        logic [CW:0]           w_space;

        logic [CW-1:0]         r_count;
        logic [PW-1:0]         r_rd_ptr, r_wr_ptr;
        logic [ADDR_WIDTH-1:0] r_mem_addr [FIFO_DEPTH];
        logic [DATA_W-1:0]     r_mem_data [FIFO_DEPTH];
        logic                  r_wr_en;
        logic [ADDR_WIDTH-1:0] r_wr_addr;
        logic [DATA_W-1:0]     r_wr_data;

        assign w_a_hit = in_a_valid && (in_a_bank == (k != 0));
        assign w_b_hit = in_b_valid && (in_b_bank == (k != 0));
        assign w_pop   = (r_count != '0);

        // Queued work always wins; new arrivals go behind it, A ahead of B.
        always_comb begin
            w_sel      = 1'b0;
            w_sel_addr = in_a_addr;
            w_sel_data = in_a_data;
            w_p0_v     = 1'b0;
            w_p0_addr  = in_a_addr;
            w_p0_data  = in_a_data;
            w_p1_v     = 1'b0;
            if (w_pop) begin
                w_sel      = 1'b1;
                w_sel_addr = r_mem_addr[r_rd_ptr];
                w_sel_data = r_mem_data[r_rd_ptr];
                if (w_a_hit) begin
                    w_p0_v = 1'b1;
                    w_p1_v = w_b_hit;
                end else if (w_b_hit) begin
                    w_p0_v    = 1'b1;
                    w_p0_addr = in_b_addr;
                    w_p0_data = in_b_data;
                end
            end else if (w_a_hit) begin
                w_sel = 1'b1;
                if (w_b_hit) begin
                    w_p0_v    = 1'b1;
                    w_p0_addr = in_b_addr;
                    w_p0_data = in_b_data;
                end
            end else if (w_b_hit) begin
                w_sel      = 1'b1;
                w_sel_addr = in_b_addr;
                w_sel_data = in_b_data;
            end
        end

        // Free slots after this cycle's pop; the newest push is dropped first.
        assign w_space   = (CW+1)'(FIFO_DEPTH) - {1'b0, r_count} + (CW+1)'(w_pop);
        assign w_p0_ok   = w_p0_v && (w_space >= (CW+1)'(1));
        assign w_p1_ok   = w_p1_v && (w_space >= (CW+1)'(2));
        assign w_drop[k] = (w_p0_v && !w_p0_ok) || (w_p1_v && !w_p1_ok);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_count   <= '0;
                r_rd_ptr  <= '0;
                r_wr_ptr  <= '0;
                r_wr_en   <= 1'b0;
                r_wr_addr <= '0;
                r_wr_data <= '0;
            end else begin
                r_count <= r_count + CW'(w_p0_ok) + CW'(w_p1_ok) - CW'(w_pop);
                if (w_pop)
                    r_rd_ptr <= f_inc(r_rd_ptr);
                if (w_p1_ok)
                    r_wr_ptr <= f_inc(f_inc(r_wr_ptr));
                else if (w_p0_ok)
                    r_wr_ptr <= f_inc(r_wr_ptr);
                r_wr_en <= w_sel;
                if (w_sel) begin
                    r_wr_addr <= w_sel_addr;
                    r_wr_data <= w_sel_data;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                if (w_p0_ok) begin
                    r_mem_addr[r_wr_ptr] <= w_p0_addr;
                    r_mem_data[r_wr_ptr] <= w_p0_data;
                end
                if (w_p1_ok) begin
                    r_mem_addr[f_inc(r_wr_ptr)] <= in_b_addr;
                    r_mem_data[f_inc(r_wr_ptr)] <= in_b_data;
                end
            end
        end

        assign w_wr_en[k]   = r_wr_en;
        assign w_wr_addr[k] = r_wr_addr;
        assign w_wr_data[k] = r_wr_data;
        assign w_count[k]   = r_count;
    end

    // Completion needs empty queues and no arrivals, so it never overlaps a write.
    assign w_fire = (r_done_latch || ctrl_done) && (w_count[0] == '0) &&
                    (w_count[1] == '0) && !in_a_valid && !in_b_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow   <= 1'b0;
            r_done_latch <= 1'b0;
            r_store_done <= 1'b0;
        end else begin
            r_overflow   <= r_overflow || (w_drop != 2'b00);
            r_done_latch <= w_fire ? 1'b0 : (r_done_latch || ctrl_done);
            r_store_done <= w_fire;
        end
    end

    assign wr_en_0       = w_wr_en[0];
    assign wr_addr_0     = w_wr_addr[0];
    assign wr_data_0     = w_wr_data[0];
    assign wr_en_1       = w_wr_en[1];
    assign wr_addr_1     = w_wr_addr[1];
    assign wr_data_1     = w_wr_data[1];
    assign pending_cnt_0 = w_count[0];
    assign pending_cnt_1 = w_count[1];
    assign overflow      = r_overflow;
    assign store_done    = r_store_done;

endmodule
`default_nettype wire
